// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single shared memory port.
// Round-robin grant, one outstanding access at a time, read timeout.
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0_valid,
    input  logic                  req0_write,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_done,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    output logic                  req0_err,

    input  logic                  req1_valid,
    input  logic                  req1_write,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_done,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic                  req1_err,

    output logic                  mem_write_en,
    output logic                  mem_read_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic                  mem_ready,

    output logic                  busy
);

    // Wide enough to hold TIMEOUT itself, so the counter can never wrap.
    localparam int CNT_WIDTH = $clog2(TIMEOUT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;

    logic                  lat_write;
    logic                  lat_id;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  last_grant;

    logic                  elig0;
    logic                  elig1;
    logic                  grant;
    logic                  grant_id;
    logic                  finish;
    logic                  finish_read;
    logic                  finish_err;
    logic                  cnt_clr;
    logic                  cnt_inc;

    // A requester whose done pulse is on the bus this cycle may not be re-granted.
    assign elig0 = req0_valid & ~req0_done;
    assign elig1 = req1_valid & ~req1_done;

    // Memory strobes and busy decode straight from state so reset clears them at once.
    assign mem_write_en = (state == ISSUE) &  lat_write;
    assign mem_read_en  = (state == ISSUE) & ~lat_write;
    assign busy         = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks so every register
            // samples pre-edge values regardless of statement order.
            state <= state_next;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        // NOTE: every output gets a default first; a path that skips an
        // assignment would otherwise infer a latch.
        state_next  = state;
        grant       = 1'b0;
        grant_id    = 1'b0;
        finish      = 1'b0;
        finish_read = 1'b0;
        finish_err  = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;

        unique case (state)
            IDLE: begin
                if (elig0 || elig1) begin
                    grant      = 1'b1;
                    grant_id   = (elig0 && elig1) ? ~last_grant : elig1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (lat_write) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_clr    = 1'b1;
                    state_next = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (mem_ready) begin
                    finish      = 1'b1;
                    finish_read = 1'b1;
                    state_next  = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                    if (cnt == CNT_LAST) begin
                        finish     = 1'b1;
                        finish_err = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Grant capture, round-robin pointer and timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_write   <= 1'b0;
            lat_id      <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            last_grant  <= 1'b1;
            cnt         <= '0;
        end else begin
            if (grant) begin
                lat_id      <= grant_id;
                last_grant  <= grant_id;
                lat_write   <= grant_id ? req1_write : req0_write;
                mem_addr    <= grant_id ? req1_addr  : req0_addr;
                mem_data_in <= grant_id ? req1_wdata : req0_wdata;
            end
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Completion pulses and per-requester response registers (held between pulses).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            req0_rdata <= '0;
            req1_rdata <= '0;
            req0_err   <= 1'b0;
            req1_err   <= 1'b0;
        end else begin
            req0_done <= finish & ~lat_id;
            req1_done <= finish &  lat_id;
            if (finish && !lat_id) begin
                req0_err <= finish_err;
                if (finish_read) begin
                    req0_rdata <= mem_data_out;
                end else if (finish_err) begin
                    req0_rdata <= '0;
                end
            end
            if (finish && lat_id) begin
                req1_err <= finish_err;
                if (finish_read) begin
                    req1_rdata <= mem_data_out;
                end else if (finish_err) begin
                    req1_rdata <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction table plus corner sequences.
module tb_mem_port_arbiter;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req0_write = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_wdata = '0;
    logic          req0_done, req0_err;
    logic [DW-1:0] req0_rdata;
    logic          req1_valid = 1'b0, req1_write = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_wdata = '0;
    logic          req1_done, req1_err;
    logic [DW-1:0] req1_rdata;
    logic          mem_write_en, mem_read_en, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out = 8'h5A;
    logic          mem_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_done(req0_done), .req0_rdata(req0_rdata),
        .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_done(req1_done), .req1_rdata(req1_rdata),
        .req1_err(req1_err),
        .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .mem_ready(mem_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            id;
        bit            write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            rdelay;    // WAIT_RD cycle on which ready is raised; 0 = never
        logic [DW-1:0] mdata;
        int            lat;       // cycles from request/grant to done
        logic [DW-1:0] exp_rdata;
        bit            exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic v, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (id == 0) begin
            req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d;
        end
    endtask

    // One transaction from an idle arbiter; plays the memory side as well.
    task automatic do_txn(input vec_t v);
        int  strobe_cyc = 0;
        int  strobes = 0;
        bit  done_seen = 0;
        logic my_done, other_done;
        step();
        check("idle_before_txn", busy, 1'b0);
        set_req(v.id, 1'b1, v.write, v.addr, v.wdata);
        for (int k = 1; k <= 60; k++) begin
            step();
            mem_ready = 1'b0;
            mem_data_out = 8'h5A;
            if (mem_write_en || mem_read_en) begin
                strobes++;
                strobe_cyc = k;
                check("strobe_cycle", k, 1);
                check("strobe_write", mem_write_en, v.write);
                check("strobe_read", mem_read_en, !v.write);
                check("strobe_addr", mem_addr, v.addr);
                if (v.write) check("strobe_wdata", mem_data_in, v.wdata);
            end
            if (!v.write && strobe_cyc > 0 && v.rdelay > 0 && k == strobe_cyc + v.rdelay) begin
                mem_ready = 1'b1;
                mem_data_out = v.mdata;
            end
            my_done    = (v.id == 0) ? req0_done : req1_done;
            other_done = (v.id == 0) ? req1_done : req0_done;
            if (other_done) check("done_wrong_requester", other_done, 1'b0);
            if (my_done) begin
                done_seen = 1;
                check("done_latency", k, v.lat);
                check("done_rdata", (v.id == 0) ? req0_rdata : req1_rdata, v.exp_rdata);
                check("done_err", (v.id == 0) ? req0_err : req1_err, v.exp_err);
                check("idle_at_done", busy, 1'b0);
                set_req(v.id, 1'b0, 1'b0, '0, '0);
                break;
            end
        end
        mem_ready = 1'b0;
        if (!done_seen) begin
            check("done_timeout", 0, 1);
            set_req(v.id, 1'b0, 1'b0, '0, '0);
        end
        check("strobe_count", strobes, 1);
        step();
        check("done_single_cycle", {req0_done, req1_done}, 2'b00);
        check("rdata_hold", (v.id == 0) ? req0_rdata : req1_rdata, v.exp_rdata);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int   grants[$];
        int   prev;
        int   ngrant;
        bit   any_done;

        //         id wr addr  wdata  rdel mdata  lat   rdata  err
        vecs[0] = '{0, 1, 4'h3, 8'hA5, 0, 8'h00, 2,      8'h00, 0};
        vecs[1] = '{1, 0, 4'h5, 8'h00, 1, 8'hFF, 3,      8'hFF, 0};
        vecs[2] = '{0, 0, 4'h9, 8'h00, 3, 8'h3C, 5,      8'h3C, 0};
        vecs[3] = '{1, 1, 4'hF, 8'h00, 0, 8'h00, 2,      8'hFF, 0};
        vecs[4] = '{0, 0, 4'h2, 8'h00, 0, 8'h00, 2 + TO, 8'h00, 1};
        vecs[5] = '{1, 0, 4'h7, 8'h00, TO, 8'h81, 2 + TO, 8'h81, 0};
        vecs[6] = '{0, 1, 4'h1, 8'h5A, 0, 8'h00, 2,      8'h00, 0};

        // Reset state.
        step();
        check("rst_busy", busy, 1'b0);
        check("rst_strobes", {mem_write_en, mem_read_en}, 2'b00);
        check("rst_done", {req0_done, req1_done}, 2'b00);
        check("rst_err", {req0_err, req1_err}, 2'b00);
        check("rst_rdata", {req0_rdata, req1_rdata}, 16'h0000);
        check("rst_mem_addr", mem_addr, 4'h0);
        check("rst_mem_data_in", mem_data_in, 8'h00);
        apply_reset();

        // Transaction table.
        for (int i = 0; i < 7; i++) do_txn(vecs[i]);

        // mem_ready pulsed in IDLE is ignored.
        step();
        mem_ready = 1'b1;
        mem_data_out = 8'hEE;
        step();
        mem_ready = 1'b0;
        mem_data_out = 8'h5A;
        check("ready_idle_busy", busy, 1'b0);
        check("ready_idle_done", {req0_done, req1_done}, 2'b00);
        step();
        check("ready_idle_done2", {req0_done, req1_done}, 2'b00);
        check("ready_idle_rdata", req1_rdata, 8'h81);

        // Reset in WAIT_RD aborts with no done pulse.
        set_req(1, 1'b1, 1'b0, 4'h6, 8'h00);
        step();                     // ISSUE
        check("abort_issue_read", mem_read_en, 1'b1);
        step();                     // WAIT_RD
        check("abort_in_wait", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_strobes", {mem_write_en, mem_read_en}, 2'b00);
        check("abort_mem_addr", mem_addr, 4'h0);
        check("abort_rdata", req1_rdata, 8'h00);
        set_req(1, 1'b0, 1'b0, '0, '0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("abort_no_done", {req0_done, req1_done}, 2'b00);
        end
        do_txn('{1, 0, 4'h5, 8'h00, 1, 8'h42, 3, 8'h42, 0});

        // Both requesters valid from reset: grants alternate starting with 0.
        apply_reset();
        set_req(0, 1'b1, 1'b1, 4'h0, 8'h10);
        set_req(1, 1'b1, 1'b1, 4'h1, 8'h11);
        prev = -1;
        ngrant = 0;
        for (int k = 0; k < 60 && ngrant < 6; k++) begin
            step();
            check("rr_done0", req0_done, prev == 0);
            check("rr_done1", req1_done, prev == 1);
            prev = -1;
            if (mem_write_en) begin
                prev = int'(mem_addr[0]);
                grants.push_back(prev);
                check("rr_order", prev, ngrant % 2);
                ngrant++;
            end
        end
        step();
        check("rr_last_done", {req1_done, req0_done}, (prev == 1) ? 2'b10 : 2'b01);
        check("rr_grant_count", ngrant, 6);
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        any_done = 0;
        for (int i = 1; i < grants.size(); i++) begin
            if (grants[i] == grants[i-1]) any_done = 1;
        end
        check("rr_no_repeat", any_done, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of all data buses.
REQ-002 Parameter ADDR_WIDTH, default 4, width of all address buses.
REQ-003 Parameter TIMEOUT, default 15, legal range 1..255; max WAIT_RD cycles before error.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 reqN_valid  in  1  requester N (N=0,1) has an access pending.
REQ-007 reqN_write  in  1  1=write, 0=read.
REQ-008 reqN_addr  in  ADDR_WIDTH  access address.
REQ-009 reqN_wdata  in  DATA_WIDTH  write data.
REQ-010 reqN_done  out  1  single-cycle completion pulse to requester N.
REQ-011 reqN_rdata  out  DATA_WIDTH  read data; valid while reqN_done=1.
REQ-012 reqN_err  out  1  timeout flag; valid while reqN_done=1.
REQ-013 mem_write_en  out  1  write strobe to shared memory port.
REQ-014 mem_read_en  out  1  read strobe to shared memory port.
REQ-015 mem_addr  out  ADDR_WIDTH  memory address.
REQ-016 mem_data_in  out  DATA_WIDTH  memory write data.
REQ-017 mem_data_out  in  DATA_WIDTH  memory read data.
REQ-018 mem_ready  in  1  memory read-complete strobe.
REQ-019 busy  out  1  high in any state other than IDLE.

Function
REQ-020 FSM SHALL have states IDLE, ISSUE, WAIT_RD.
REQ-021 IDLE: if any eligible reqN_valid, SHALL select a winner, latch its write/addr/wdata, go to ISSUE next cycle.
REQ-022 Both eligible: SHALL grant the requester not granted last (round-robin); last_grant updates on every grant.
REQ-023 Requester N SHALL be ineligible in the cycle its reqN_done=1.
REQ-024 ISSUE: SHALL assert exactly one of mem_write_en/mem_read_en for exactly one cycle, with mem_addr/mem_data_in from the latched values.
REQ-025 mem_write_en, mem_read_en SHALL be 0 in IDLE and WAIT_RD; mem_addr/mem_data_in SHALL hold the latched values in all states.
REQ-026 ISSUE write: next state IDLE; reqN_done=1, reqN_err=0 in that next cycle (latency 2 cycles from grant to done).
REQ-027 ISSUE read: next state WAIT_RD; timeout counter cleared to 0.
REQ-028 WAIT_RD, mem_ready=1: SHALL capture mem_data_out into reqN_rdata, go IDLE, pulse reqN_done (err=0) next cycle.
REQ-029 WAIT_RD, mem_ready=0: counter increments; upon reaching TIMEOUT, SHALL go IDLE, pulse reqN_done with reqN_err=1 and reqN_rdata=0.
REQ-030 mem_ready SHALL be ignored in IDLE and ISSUE.
REQ-031 Nominal read (memory ready one cycle after read_en): grant-to-done latency 3 cycles.
REQ-032 reqN_done SHALL never be asserted for the non-granted requester; at most one done per cycle.
REQ-033 Requests arriving while busy=1 SHALL wait; requester holds valid and fields stable until its done.
REQ-034 reqN_rdata, reqN_err SHALL hold their last value outside done pulses.
REQ-035 Timeout counter SHALL be $clog2(TIMEOUT+1) bits and never wrap.

Reset
REQ-036 rst_n low SHALL immediately force IDLE, all done/err/strobes/busy=0, rdata=0, mem_addr=0, mem_data_in=0, counter=0, last_grant=1 (requester 0 wins first tie).
REQ-037 Reset mid-transaction SHALL abort it with no done pulse emitted.

Verification
REQ-038 req0 write addr=3 data=0xA5 -> mem_write_en one cycle, addr=3, data_in=0xA5; req0_done 2 cycles after grant, err=0.
REQ-039 req1 read addr=5, memory returns 0xFF with ready one cycle later -> req1_done with rdata=0xFF, err=0, 3 cycles after grant.
REQ-040 Both valid continuously from reset -> grants alternate 0,1,0,1; no requester granted twice consecutively.
REQ-041 Read with mem_ready tied 0, TIMEOUT=15 -> done with err=1, rdata=0 after 15 WAIT_RD cycles; FSM returns IDLE.
REQ-042 rst_n asserted during WAIT_RD -> busy=0 and strobes=0 immediately; no done pulse; next request serviced normally.
REQ-043 mem_ready pulsed during IDLE -> no done, no state change.
